// File: rtl/simple_data_mem_pkg.sv
// Shared constants for the simple_riscv core and its data memory.
// Default widths and the instruction opcode encoding common to both sides.
package simple_data_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5
    } opcode_e;

endpackage

// File: rtl/simple_data_mem_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: hold once every bit is set
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/simple_data_mem.sv
// Data memory beside the simple_riscv core: register array, registered read
// port with held data, bench preload/peek port and saturating access counters.
module simple_data_mem
    import simple_data_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    output logic              rd_valid,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              collide
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              rd_valid_q, rd_valid_d;
    logic              collide_q, collide_d;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              core_wr_s;

    // preload outranks the core; the losing core write is simply dropped
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = addr;
        wr_data_s = data_out;
        if (ld_we) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ld_addr;
            wr_data_s = ld_data;
        end else if (mem_write) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr;
            wr_data_s = data_out;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    assign core_wr_s = mem_write & ~ld_we;

    // read register next-state: write-first bypass when the winning write hits addr
    always_comb begin
        data_in_d  = data_in_q;
        rd_valid_d = mem_read;
        collide_d  = collide_q | (ld_we & mem_write);
        if (mem_read) begin
            if (wr_en_s && (wr_addr_s == addr)) begin
                data_in_d = wr_data_s;
            end else begin
                data_in_d = mem_q[addr];
            end
        end else begin
            data_in_d = data_in_q;
        end
    end

    // array, read register and sticky collide flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            data_in_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            collide_q  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_addr_s] <= wr_data_s;
            end
            data_in_q  <= data_in_d;
            rd_valid_q <= rd_valid_d;
            collide_q  <= collide_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .clear (~reset_n),
        .inc   (mem_read),
        .cnt   (rd_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .clear (~reset_n),
        .inc   (core_wr_s),
        .cnt   (wr_count)
    );

    assign data_in  = data_in_q;
    assign rd_valid = rd_valid_q;
    assign collide  = collide_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule
